// File: rtl/mask_match_sequencer_pkg.sv
// Shared sizing constants, FSM state type and popcount helper for the
// bitmask-pair match sequencer.
package mask_match_sequencer_pkg;

  localparam int MASK_WIDTH = 16;
  localparam int IDX_WIDTH  = 4;
  localparam int CNT_WIDTH  = IDX_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Count is one bit wider than an index so a full mask reports 16, not 0.
  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [MASK_WIDTH-1:0] v);
    logic [CNT_WIDTH-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < MASK_WIDTH; i++) begin
      cnt = cnt + CNT_WIDTH'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/match_priority_enc.sv
// Lowest-set-bit encoder over the remaining matches, plus the offsets into
// the compressed W and A streams for that lane.
module match_priority_enc
  import mask_match_sequencer_pkg::*;
(
  input  logic [MASK_WIDTH-1:0] rem,
  input  logic [MASK_WIDTH-1:0] w,
  input  logic [MASK_WIDTH-1:0] a,
  output logic [IDX_WIDTH-1:0]  pos,
  output logic [IDX_WIDTH-1:0]  idxW,
  output logic [IDX_WIDTH-1:0]  idxA,
  output logic                  single
);

  localparam logic [MASK_WIDTH-1:0] ONE = MASK_WIDTH'(1);

  logic [MASK_WIDTH-1:0] low_bit;
  logic [MASK_WIDTH-1:0] below;

  always_comb begin
    pos = '0;
    for (int i = MASK_WIDTH - 1; i >= 0; i--) begin
      if (rem[i]) pos = IDX_WIDTH'(i);
    end
  end

  // Offsets count strictly below the match, so at most 15 and fit IDX_WIDTH.
  assign low_bit = rem & (~rem + ONE);
  assign below   = low_bit - ONE;
  assign idxW    = IDX_WIDTH'(popcount(w & below));
  assign idxA    = IDX_WIDTH'(popcount(a & below));
  assign single  = (rem != '0) && ((rem & (rem - ONE)) == '0);

endmodule

// File: rtl/mask_match_sequencer.sv
// Walks the common non-zero lanes of a W/A bitmask pair one match at a time,
// then reports how far each compressed stream pointer must advance.
module mask_match_sequencer #(
  parameter int MASK_WIDTH = 16,
  parameter int IDX_WIDTH  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MASK_WIDTH-1:0] in_bitmaskW,
  input  logic [MASK_WIDTH-1:0] in_bitmaskA,
  input  logic                  in_tile_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_WIDTH-1:0]  out_pos,
  output logic [IDX_WIDTH-1:0]  out_idxW,
  output logic [IDX_WIDTH-1:0]  out_idxA,
  output logic                  out_last,
  output logic                  done_valid,
  output logic [IDX_WIDTH:0]    done_countW,
  output logic [IDX_WIDTH:0]    done_countA,
  output logic                  done_tile_last,
  output logic                  busy
);

  import mask_match_sequencer_pkg::*;

  localparam logic [MASK_WIDTH-1:0] ONE = MASK_WIDTH'(1);

  state_t                state;
  state_t                next_state;
  logic [MASK_WIDTH-1:0] w_reg;
  logic [MASK_WIDTH-1:0] a_reg;
  logic [MASK_WIDTH-1:0] rem;
  logic                  tile_last_reg;
  logic [IDX_WIDTH-1:0]  enc_pos;
  logic [IDX_WIDTH-1:0]  enc_idx_w;
  logic [IDX_WIDTH-1:0]  enc_idx_a;
  logic                  enc_single;
  logic                  accept;
  logic                  consume;

  assign accept  = (state == IDLE) && in_valid;
  assign consume = (state == SCAN) && out_ready;

  match_priority_enc u_enc (
    .rem    (rem),
    .w      (w_reg),
    .a      (a_reg),
    .pos    (enc_pos),
    .idxW   (enc_idx_w),
    .idxA   (enc_idx_a),
    .single (enc_single)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      w_reg         <= '0;
      a_reg         <= '0;
      rem           <= '0;
      tile_last_reg <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        w_reg         <= in_bitmaskW;
        a_reg         <= in_bitmaskA;
        rem           <= in_bitmaskW & in_bitmaskA;
        tile_last_reg <= in_tile_last;
      end else if (consume) begin
        rem <= rem & (rem - ONE);
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = ((in_bitmaskW & in_bitmaskA) != '0) ? SCAN : DONE;
      SCAN:    if (out_ready && enc_single) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // in_ready is gated by reset itself so every output reads 0 while it is held.
  always_comb begin
    in_ready       = (state == IDLE) && !reset;
    busy           = (state != IDLE);
    out_valid      = (state == SCAN);
    out_pos        = '0;
    out_idxW       = '0;
    out_idxA       = '0;
    out_last       = 1'b0;
    done_valid     = (state == DONE);
    done_countW    = '0;
    done_countA    = '0;
    done_tile_last = 1'b0;
    if (state == SCAN) begin
      out_pos  = enc_pos;
      out_idxW = enc_idx_w;
      out_idxA = enc_idx_a;
      out_last = enc_single;
    end
    if (state == DONE) begin
      done_countW    = popcount(w_reg);
      done_countA    = popcount(a_reg);
      done_tile_last = tile_last_reg;
    end
  end

endmodule

// File: tb/tb_mask_match_sequencer.sv
// Randomized and directed bench for mask_match_sequencer, checked every cycle
// against a transaction-level model built from per-pair match lists.
module tb_mask_match_sequencer;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_bitmaskW;
  logic [15:0] in_bitmaskA;
  logic        in_tile_last;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_pos;
  logic [3:0]  out_idxW;
  logic [3:0]  out_idxA;
  logic        out_last;
  logic        done_valid;
  logic [4:0]  done_countW;
  logic [4:0]  done_countA;
  logic        done_tile_last;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  int q_pos[$];
  int q_iw[$];
  int q_ia[$];
  int q_last[$];
  bit m_busy = 0;
  int m_cw = 0;
  int m_ca = 0;
  int m_tl = 0;

  mask_match_sequencer #(.MASK_WIDTH(16), .IDX_WIDTH(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_bitmaskW    (in_bitmaskW),
    .in_bitmaskA    (in_bitmaskA),
    .in_tile_last   (in_tile_last),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pos        (out_pos),
    .out_idxW       (out_idxW),
    .out_idxA       (out_idxA),
    .out_last       (out_last),
    .done_valid     (done_valid),
    .done_countW    (done_countW),
    .done_countA    (done_countA),
    .done_tile_last (done_tile_last),
    .busy           (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // A pair becomes the ordered list of lanes where both masks are set.
  task automatic modelAccept(input logic [15:0] w, input logic [15:0] a, input logic tl);
    q_pos.delete(); q_iw.delete(); q_ia.delete(); q_last.delete();
    for (int i = 0; i < 16; i++) begin
      if (w[i] && a[i]) begin
        int cw = 0;
        int ca = 0;
        for (int j = 0; j < i; j++) begin
          cw += int'(w[j]);
          ca += int'(a[j]);
        end
        q_pos.push_back(i); q_iw.push_back(cw); q_ia.push_back(ca); q_last.push_back(0);
      end
    end
    if (q_last.size() > 0) q_last[q_last.size()-1] = 1;
    m_cw = $countones(w);
    m_ca = $countones(a);
    m_tl = int'(tl);
    m_busy = 1;
  endtask

  task automatic modelStep();
    if (!m_busy) begin
      if (in_valid) modelAccept(in_bitmaskW, in_bitmaskA, in_tile_last);
    end else if (q_pos.size() > 0) begin
      if (out_ready) begin
        void'(q_pos.pop_front()); void'(q_iw.pop_front());
        void'(q_ia.pop_front()); void'(q_last.pop_front());
      end
    end else begin
      m_busy = 0;
    end
  endtask

  task automatic checkOutput();
    bit showing = m_busy && (q_pos.size() > 0);
    bit finishing = m_busy && (q_pos.size() == 0);
    check("in_ready", int'(in_ready), int'(!m_busy));
    check("busy", int'(busy), int'(m_busy));
    check("out_valid", int'(out_valid), int'(showing));
    check("out_pos", int'(out_pos), showing ? q_pos[0] : 0);
    check("out_idxW", int'(out_idxW), showing ? q_iw[0] : 0);
    check("out_idxA", int'(out_idxA), showing ? q_ia[0] : 0);
    check("out_last", int'(out_last), showing ? q_last[0] : 0);
    check("done_valid", int'(done_valid), int'(finishing));
    check("done_countW", int'(done_countW), finishing ? m_cw : 0);
    check("done_countA", int'(done_countA), finishing ? m_ca : 0);
    check("done_tile_last", int'(done_tile_last), finishing ? m_tl : 0);
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] w, input logic [15:0] a,
                               input logic tl, input logic ordy);
    in_valid = v; in_bitmaskW = w; in_bitmaskA = a; in_tile_last = tl; out_ready = ordy;
    @(negedge clock);
    checkOutput();
    modelStep();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (m_busy && n < 40) begin
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      n++;
    end
    check("drain_busy", int'(busy), 0);
  endtask

  function automatic logic [15:0] randMask();
    case ($urandom_range(0, 4))
      0: return 16'($urandom);
      1: return 16'($urandom & $urandom);
      2: return 16'hFFFF;
      3: return 16'($urandom) & 16'h0F0F;
      default: return 16'h0000;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_bitmaskW = '0; in_bitmaskA = '0; in_tile_last = 1'b0; out_ready = 1'b0;
    #2;
    check("reset_in_ready", int'(in_ready), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_done_valid", int'(done_valid), 0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Basic match
    applyStimulus(1'b1, 16'h00FF, 16'h0F0F, 1'b0, 1'b1);
    check("basic_model_len", q_pos.size(), 4);
    check("basic_model_last", q_last[3], 1);
    check("basic_model_cw", m_cw, 8);
    check("basic_model_ca", m_ca, 8);
    check("basic_first_pos", int'(out_pos), 0);
    drain();

    // Empty match reports counts the very next cycle
    applyStimulus(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b1);
    check("empty_done_valid", int'(done_valid), 1);
    check("empty_countW", int'(done_countW), 16);
    check("empty_countA", int'(done_countA), 0);
    check("empty_tile_last", int'(done_tile_last), 1);
    check("empty_out_valid", int'(out_valid), 0);
    drain();

    // Stall holds the first match
    applyStimulus(1'b1, 16'h8001, 16'h8001, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    check("stall_held_pos", int'(out_pos), 0);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    check("stall_pos", int'(out_pos), 15);
    check("stall_idxW", int'(out_idxW), 1);
    check("stall_idxA", int'(out_idxA), 1);
    check("stall_last", int'(out_last), 1);
    drain();

    // Asymmetric masks
    applyStimulus(1'b1, 16'hAAAA, 16'hFFFF, 1'b0, 1'b1);
    check("asym_model_pos7", q_pos[7], 15);
    check("asym_model_iw7", q_iw[7], 7);
    check("asym_model_ia7", q_ia[7], 15);
    check("asym_model_ca", m_ca, 16);
    check("asym_first_idxA", int'(out_idxA), 1);
    drain();

    // Randomized traffic
    for (int c = 0; c < 500; c++) begin
      applyStimulus(1'($urandom_range(0, 1)), randMask(), randMask(),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 7));
    end
    drain();

    // Reset mid-scan drops the pair without a done pulse
    applyStimulus(1'b1, 16'h000F, 16'h000F, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    check("midscan_pos", int'(out_pos), 2);
    reset = 1'b1;
    #1;
    check("midscan_rst_out_valid", int'(out_valid), 0);
    check("midscan_rst_out_pos", int'(out_pos), 0);
    check("midscan_rst_in_ready", int'(in_ready), 0);
    check("midscan_rst_done_valid", int'(done_valid), 0);
    check("midscan_rst_busy", int'(busy), 0);
    q_pos.delete(); q_iw.delete(); q_ia.delete(); q_last.delete();
    m_busy = 0;
    in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("post_rst_in_ready", int'(in_ready), 1);
    check("post_rst_done_valid", int'(done_valid), 0);
    applyStimulus(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0);
    check("post_rst_out_valid", int'(out_valid), 1);
    check("post_rst_pos", int'(out_pos), 0);
    check("post_rst_last", int'(out_last), 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mask_match_sequencer.md
MASK_MATCH_SEQUENCER -- requirements
Module: mask_match_sequencer

Interface
REQ-001 SHALL have parameter MASK_WIDTH, default 16, number of bitmask lanes per pair; only 16 is required to be supported.
REQ-002 SHALL have parameter IDX_WIDTH, default 4, log2(MASK_WIDTH), width of position and offset fields.
REQ-003 SHALL have port clock  in  1  sole clock; every flop samples on its rising edge.
REQ-004 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  in  1  a bitmask pair is offered.
REQ-006 SHALL have port in_ready  out  1  the sequencer accepts a pair this cycle.
REQ-007 SHALL have port in_bitmaskW  in  16  weight non-zero mask.
REQ-008 SHALL have port in_bitmaskA  in  16  activation non-zero mask.
REQ-009 SHALL have port in_tile_last  in  1  this pair ends the tile.
REQ-010 SHALL have port out_valid  out  1  a matched position is presented.
REQ-011 SHALL have port out_ready  in  1  downstream MAC consumes the match.
REQ-012 SHALL have port out_pos  out  4  lane index of the match.
REQ-013 SHALL have port out_idxW  out  4  offset into compressed W, equal to popcount(W bits below out_pos).
REQ-014 SHALL have port out_idxA  out  4  offset into compressed A, equal to popcount(A bits below out_pos).
REQ-015 SHALL have port out_last  out  1  this is the final match of the pair.
REQ-016 SHALL have port done_valid  out  1  one-cycle pulse marking pair completion.
REQ-017 SHALL have port done_countW  out  5  popcount(W), the compressed-W pointer advance.
REQ-018 SHALL have port done_countA  out  5  popcount(A), the compressed-A pointer advance.
REQ-019 SHALL have port done_tile_last  out  1  registered copy of in_tile_last.
REQ-020 SHALL have port busy  out  1  state is not IDLE.

Function
REQ-021 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-022 IDLE SHALL drive in_ready=1; on in_valid it SHALL register W, A, tile_last and rem=W&A.
REQ-023 From IDLE after a transfer, the FSM SHALL go to SCAN if W&A!=0, else to DONE.
REQ-024 SCAN SHALL drive out_valid=1 with out_pos equal to the lowest set bit of rem; out_idxW, out_idxA and out_last (rem has exactly one bit set) SHALL all be combinational from registered state.
REQ-025 In SCAN, out_valid&&out_ready SHALL clear that bit of rem; on the final match the FSM SHALL go to DONE.
REQ-026 Outputs SHALL hold stable while out_valid&&!out_ready, for any stall length.
REQ-027 DONE SHALL assert done_valid for exactly one cycle with done_countW, done_countA and done_tile_last valid, then return to IDLE.
REQ-028 in_ready SHALL be 0 in SCAN and DONE; no overlap between pairs.
REQ-029 Latency SHALL be: pair accepted cycle N gives first out_valid at N+1; a pair with k matches occupies k+2 cycles, or 2 cycles when k=0.
REQ-030 popcount of 16 set bits SHALL give 5'd16 without wrap.
REQ-031 out_* SHALL be 0 when out_valid=0; done_* SHALL be 0 when done_valid=0.

Reset
REQ-032 Assertion of reset SHALL immediately force IDLE, clear all registers, and drive every output to 0, including in_ready.
REQ-033 Reset mid-SCAN SHALL drop in-flight matches with no done_valid; in_ready SHALL be 1 in the first cycle after release.

Structure
REQ-034 MASK_WIDTH, IDX_WIDTH, count width (IDX_WIDTH+1) and the FSM state enum SHALL live in a shared package, e.g. sparse_match_pkg.
REQ-035 The lowest-set-bit encoder plus masked popcount SHALL be one sub-module, match_priority_enc: rem, W, A in; pos, idxW, idxA, single out.

Verification
REQ-036 Basic match: W=0x00FF, A=0x0F0F -> pos 0..3 with idxW=idxA=pos, out_last at pos 3; done countW=8, countA=8.
REQ-037 Empty match: W=0xFFFF, A=0x0000, tile_last=1 -> no out_valid; done_valid at N+1 with countW=16, countA=0, tile_last=1.
REQ-038 Stall: W=A=0x8001, out_ready low 3 cycles -> pos 0 held 3 cycles; then pos 15, idxW=1, idxA=1, out_last=1.
REQ-039 Asymmetric: W=0xAAAA, A=0xFFFF -> (pos,idxW,idxA) = (1,0,1), (3,1,3) ... (15,7,15); countW=8, countA=16.
REQ-040 Reset mid-SCAN: reset after 2 of 4 matches -> outputs 0 immediately, no done_valid; next pair W=A=0x0001 gives pos 0 with out_last=1.
